frame_buf_sched: RTL and testbench
==================================

Name: frame_buf_sched

Overview:
- Triple-buffer scheduler for the SDRAM frame store between the camera write port and the VGA read port.
- Picks which of three frame regions the camera writes and which one the display reads.
- Drives the write/read base addresses and the load (address reset) pulses into the SDRAM FIFO controller, so a displayed frame is never overwritten mid-scan (no tearing).
- Sits between the capture/VGA sync logic and sdram_top, in the clk_65m domain.

Parameters:
- FRAME_SIZE, 24'd786432, words per frame (1024*768); region base = index*FRAME_SIZE.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; the system connects clk_65m.
- rst_n  input  1  asynchronous active-low reset.
- sys_init_done  input  1  level; SDRAM and camera initialised.
- wr_frame_done  input  1  one-cycle pulse; camera finished writing a frame (already synchronised to clk).
- rd_frame_start  input  1  one-cycle pulse; display entering vertical blank.
- freeze  input  1  level; 1 = hold the displayed frame.
- wr_base  output  24  write region start address.
- rd_base  output  24  read region start address.
- wr_load  output  1  one-cycle pulse; reload write address and clear the write FIFO.
- rd_load  output  1  one-cycle pulse; reload read address and clear the read FIFO.
- disp_valid  output  1  1 once the reader shows a completed frame.
- drop_cnt  output  CNT_W  frames written but never displayed.
- repeat_cnt  output  CNT_W  display frames that re-showed an old buffer.

Behaviour:
- Internal state:
  - W, R, L: 2-bit buffer indices, always pairwise distinct, values 0..2.
  - lvalid: L holds a completed frame not yet displayed.
- Reset values:
  - W=0, R=1, L=2, lvalid=0.
  - wr_base=0, rd_base=FRAME_SIZE.
  - wr_load=0, rd_load=0, disp_valid=0, drop_cnt=0, repeat_cnt=0.
  - State = WAIT_INIT.
- FSM:
  - WAIT_INIT: all event inputs ignored; go to PRIME when sys_init_done=1.
  - PRIME: assert wr_load=1 and rd_load=1 for exactly one cycle with bases from the reset indices, then go to RUN.
  - RUN: stays in RUN; returns to WAIT_INIT if sys_init_done falls, with indices, lvalid and disp_valid reset (counters kept).
- RUN, wr_frame_done only:
  - If lvalid=1, drop_cnt++.
  - Then L<=W, W<=3-R-W, lvalid<=1.
- RUN, rd_frame_start only:
  - If lvalid=1 and freeze=0: R<=L, L<=R, lvalid<=0, disp_valid<=1.
  - Otherwise R is unchanged and repeat_cnt++ (this includes freeze=1).
- RUN, both pulses in the same cycle, freeze=0: the write completion is taken first and the reader takes the just-finished frame.
  - R<=W, W<=L, L<=R, lvalid<=0, disp_valid<=1.
  - drop_cnt++ if lvalid was 1.
- RUN, both pulses in the same cycle, freeze=1: apply the wr_frame_done-only rule and repeat_cnt++.
- Outputs are registered:
  - wr_load pulses the cycle after any index change to W; wr_base updates in that same cycle.
  - rd_load pulses the cycle after every accepted rd_frame_start, including repeats, so the read address restarts each frame; rd_base = R*FRAME_SIZE is valid in that cycle.
  - Latency from event pulse to load pulse = 1 cycle.
- Bases are computed as index*FRAME_SIZE in 24 bits; 2*FRAME_SIZE+FRAME_SIZE must not exceed 2^24. No wrap handling is required.
- Counters saturate at all-ones and do not wrap.
- Back-to-back pulses on consecutive cycles are each processed; no event is lost.
- Asynchronous reset mid-frame restores all reset values immediately; loads are re-issued only through PRIME.

Optional Feature:
- Macro FRAME_STATS_EN.
- Defined: drop_cnt and repeat_cnt are implemented as described.
- Undefined: both outputs are tied to 0, the counter registers are not built, and scheduling is unchanged.

Test Plan:
- Reset, then sys_init_done=1 -> one cycle later wr_load=rd_load=1 for 1 cycle, wr_base=0, rd_base=786432, disp_valid=0.
- wr_frame_done, then 10 cycles later rd_frame_start -> after the first event wr_base=2*786432 and wr_load pulses; after the second rd_base=0, rd_load pulses, disp_valid=1, W/R/L=2/0/1.
- Three wr_frame_done pulses with no rd_frame_start -> drop_cnt=2, W never equals R=1, and each pulse yields a wr_load.
- wr_frame_done and rd_frame_start in the same cycle from the post-PRIME state -> rd_base=0, wr_base=2*786432, disp_valid=1, drop_cnt=0.
- freeze=1 with 4 rd_frame_start pulses and 4 wr_frame_done pulses -> rd_base constant, repeat_cnt=4, and rd_load pulses 4 times.
- Assert rst_n=0 mid-RUN, then release with sys_init_done=1 -> outputs return to reset values at once, then a single PRIME load pair follows.

Source files
------------

// File: rtl/frame_buf_sched.sv
// Triple-buffer scheduler for the SDRAM frame store. It steers camera writes and VGA reads across three frame regions so that the displayed frame is never overwritten.
// Define FRAME_STATS_EN to build the drop/repeat statistics counters; otherwise both outputs read 0.
module frame_buf_sched #(
    parameter logic [23:0] FRAME_SIZE = 24'd786432,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sys_init_done,
    input  logic             wr_frame_done,
    input  logic             rd_frame_start,
    input  logic             freeze,
    output logic [23:0]      wr_base,
    output logic [23:0]      rd_base,
    output logic             wr_load,
    output logic             rd_load,
    output logic             disp_valid,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] repeat_cnt
);

    typedef enum logic [1:0] {WAIT_INIT, PRIME, RUN} state_t;

    state_t      state_q;
    logic [1:0]  w_q, r_q, l_q;
    logic [1:0]  w_d, r_d, l_d;
    logic        lvalid_q, lvalid_d, show_d;
    logic [23:0] wr_base_q, rd_base_q;
    logic        wr_load_q, rd_load_q, disp_valid_q;

    // Each index is at most 2, so a mux replaces the multiplier.
    function automatic logic [23:0] base_of(input logic [1:0] idx);
        return idx[1] ? (FRAME_SIZE << 1) : (idx[0] ? FRAME_SIZE : 24'd0);
    endfunction

    always_comb begin
        w_d      = w_q;
        r_d      = r_q;
        l_d      = l_q;
        lvalid_d = lvalid_q;
        show_d   = 1'b0;
        if (wr_frame_done && rd_frame_start && !freeze) begin
            // The reader takes the frame that has just been completed.
            r_d      = w_q;
            w_d      = l_q;
            l_d      = r_q;
            lvalid_d = 1'b0;
            show_d   = 1'b1;
        end else begin
            if (wr_frame_done) begin
                l_d      = w_q;
                w_d      = 2'd3 - r_q - w_q;
                lvalid_d = 1'b1;
            end
            if (rd_frame_start && lvalid_q && !freeze) begin
                r_d      = l_q;
                l_d      = r_q;
                lvalid_d = 1'b0;
                show_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_INIT;
            w_q          <= 2'd0;
            r_q          <= 2'd1;
            l_q          <= 2'd2;
            lvalid_q     <= 1'b0;
            wr_base_q    <= 24'd0;
            rd_base_q    <= FRAME_SIZE;
            wr_load_q    <= 1'b0;
            rd_load_q    <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            wr_load_q <= 1'b0;
            rd_load_q <= 1'b0;
            case (state_q)
                WAIT_INIT: if (sys_init_done) begin
                    state_q   <= PRIME;
                    wr_load_q <= 1'b1;
                    rd_load_q <= 1'b1;
                    wr_base_q <= base_of(w_q);
                    rd_base_q <= base_of(r_q);
                end
                PRIME: state_q <= RUN;
                RUN: if (!sys_init_done) begin
                    state_q      <= WAIT_INIT;
                    w_q          <= 2'd0;
                    r_q          <= 2'd1;
                    l_q          <= 2'd2;
                    lvalid_q     <= 1'b0;
                    disp_valid_q <= 1'b0;
                    wr_base_q    <= 24'd0;
                    rd_base_q    <= FRAME_SIZE;
                end else begin
                    w_q       <= w_d;
                    r_q       <= r_d;
                    l_q       <= l_d;
                    lvalid_q  <= lvalid_d;
                    wr_load_q <= wr_frame_done;
                    rd_load_q <= rd_frame_start;
                    wr_base_q <= base_of(w_d);
                    rd_base_q <= base_of(r_d);
                    if (show_d) disp_valid_q <= 1'b1;
                end
                default: state_q <= WAIT_INIT;
            endcase
        end
    end

`ifdef FRAME_STATS_EN
    logic             run_act, drop_inc, rep_inc;
    logic [CNT_W-1:0] drop_q, rep_q;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        run_act  = (state_q == RUN) && sys_init_done;
        drop_inc = run_act && wr_frame_done && lvalid_q;
        // A simultaneous write completion gives an unfrozen reader a fresh frame.
        rep_inc  = run_act && rd_frame_start && (freeze || (!wr_frame_done && !lvalid_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
            rep_q  <= '0;
        end else begin
            if (drop_inc && drop_q != '1) drop_q <= drop_q + ONE;
            if (rep_inc && rep_q != '1)   rep_q  <= rep_q + ONE;
        end
    end

    assign drop_cnt   = drop_q;
    assign repeat_cnt = rep_q;
`else
    assign drop_cnt   = '0;
    assign repeat_cnt = '0;
`endif

    assign wr_base    = wr_base_q;
    assign rd_base    = rd_base_q;
    assign wr_load    = wr_load_q;
    assign rd_load    = rd_load_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Scoreboard bench for frame_buf_sched. The stimulus pushes hand-computed expected load cycles, and the monitor pops one entry for each load it sees.
module tb_frame_buf_sched;
    localparam logic [23:0] FS  = 24'd786432;
    localparam logic [23:0] FS2 = 24'd1572864;
`ifdef FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, sys_init_done = 1'b0;
    logic wr_frame_done = 1'b0, rd_frame_start = 1'b0, freeze = 1'b0;
    logic [23:0] wr_base, rd_base;
    logic wr_load, rd_load, disp_valid;
    logic [15:0] drop_cnt, repeat_cnt;

    frame_buf_sched #(.FRAME_SIZE(FS), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .sys_init_done(sys_init_done),
        .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start), .freeze(freeze),
        .wr_base(wr_base), .rd_base(rd_base), .wr_load(wr_load), .rd_load(rd_load),
        .disp_valid(disp_valid), .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic wl; logic rl; logic [23:0] wb; logic [23:0] rb; logic dv; logic [15:0] dc; logic [15:0] rc;
    } exp_t;

    exp_t q[$];
    exp_t mon_a, mon_e;
    int vecs = 0, miss = 0;

    function automatic logic [15:0] c(input int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    task automatic expect_load(input logic wl, rl, input logic [23:0] wb, rb,
                               input logic dv, input logic [15:0] dc, rc);
        q.push_back(exp_t'{wl, rl, wb, rb, dv, dc, rc});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic wf, input logic rs);
        @(posedge clk); #1;
        wr_frame_done  = wf;
        rd_frame_start = rs;
    endtask

    task automatic pulse(input logic wf, input logic rs);
        drive(wf, rs);
        drive(1'b0, 1'b0);
    endtask

    // Drop sys_init_done to return to WAIT_INIT, then re-prime from the reset indices.
    task automatic reprime(input logic [15:0] dc, input logic [15:0] rc);
        @(posedge clk); #1 sys_init_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("deinit_disp_valid", 32'(disp_valid), 32'd0);
        chk("deinit_wr_base", 32'(wr_base), 32'd0);
        chk("deinit_rd_base", 32'(rd_base), 32'(FS));
        expect_load(1, 1, 24'd0, FS, 0, dc, rc);
        sys_init_done = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && (wr_load || rd_load)) begin
            mon_a = exp_t'{wr_load, rd_load, wr_base, rd_base, disp_valid, drop_cnt, repeat_cnt};
            vecs++;
            if (q.size() == 0) begin
                miss++;
                $display("FAIL unexpected_load got wl=%b rl=%b wb=%0d rb=%0d", wr_load, rd_load, wr_base, rd_base);
            end else begin
                mon_e = q.pop_front();
                if (mon_a !== mon_e) begin
                    miss++;
                    $display("FAIL load_vec got wl=%b rl=%b wb=%0d rb=%0d dv=%b drop=%0d rep=%0d expected wl=%b rl=%b wb=%0d rb=%0d dv=%b drop=%0d rep=%0d",
                             mon_a.wl, mon_a.rl, mon_a.wb, mon_a.rb, mon_a.dv, mon_a.dc, mon_a.rc,
                             mon_e.wl, mon_e.rl, mon_e.wb, mon_e.rb, mon_e.dv, mon_e.dc, mon_e.rc);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_base", 32'(wr_base), 32'd0);
        chk("rst_rd_base", 32'(rd_base), 32'(FS));
        chk("rst_wr_load", 32'(wr_load), 32'd0);
        chk("rst_rd_load", 32'(rd_load), 32'd0);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_repeat_cnt", 32'(repeat_cnt), 32'd0);
        rst_n = 1'b1;

        // Events in WAIT_INIT must be ignored.
        pulse(1, 0);
        pulse(0, 1);
        repeat (2) @(posedge clk);
        #1 chk("wait_init_wr_base", 32'(wr_base), 32'd0);

        // Initial prime.
        expect_load(1, 1, 24'd0, FS, 0, 0, 0);
        sys_init_done = 1'b1;
        repeat (3) @(posedge clk);

        // Write, then read 10 cycles later.
        expect_load(1, 0, FS2, FS, 0, 0, 0);
        pulse(1, 0);
        repeat (10) @(posedge clk);
        expect_load(0, 1, FS2, 24'd0, 1, 0, 0);
        pulse(0, 1);
        repeat (2) @(posedge clk);
        reprime(c(0), c(0));

        // Three writes, two of them back to back, with no reads.
        expect_load(1, 0, FS2, FS, 0, c(0), 0);
        expect_load(1, 0, 24'd0, FS, 0, c(1), 0);
        drive(1, 0);
        drive(1, 0);
        drive(0, 0);
        repeat (3) @(posedge clk);
        expect_load(1, 0, FS2, FS, 0, c(2), 0);
        pulse(1, 0);
        repeat (2) @(posedge clk);
        #1 chk("three_writes_drop", 32'(drop_cnt), 32'(c(2)));
        reprime(c(2), 0);

        // Simultaneous write and read, first without and then with a pending frame.
        expect_load(1, 1, FS2, 24'd0, 1, c(2), 0);
        pulse(1, 1);
        expect_load(1, 0, FS, 24'd0, 1, c(2), 0);
        pulse(1, 0);
        expect_load(1, 1, FS2, FS, 1, c(3), 0);
        pulse(1, 1);
        repeat (2) @(posedge clk);
        reprime(c(3), 0);

        // Freeze: reads repeat and writes keep rotating.
        freeze = 1'b1;
        expect_load(0, 1, 24'd0, FS, 0, c(3), c(1));
        pulse(0, 1);
        expect_load(1, 0, FS2, FS, 0, c(3), c(1));
        pulse(1, 0);
        expect_load(0, 1, FS2, FS, 0, c(3), c(2));
        pulse(0, 1);
        expect_load(1, 1, 24'd0, FS, 0, c(4), c(3));
        pulse(1, 1);
        expect_load(1, 0, FS2, FS, 0, c(5), c(3));
        pulse(1, 0);
        expect_load(0, 1, FS2, FS, 0, c(5), c(4));
        pulse(0, 1);
        expect_load(1, 0, 24'd0, FS, 0, c(6), c(4));
        pulse(1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("freeze_rd_base", 32'(rd_base), 32'(FS));
        chk("freeze_repeat_cnt", 32'(repeat_cnt), 32'(c(4)));
        freeze = 1'b0;
        expect_load(0, 1, 24'd0, FS2, 1, c(6), c(4));
        pulse(0, 1);
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-RUN while a load pulse is high.
        drive(1, 0);
        drive(0, 0);
        chk("pre_reset_wr_load", 32'(wr_load), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_wr_load", 32'(wr_load), 32'd0);
        chk("async_wr_base", 32'(wr_base), 32'd0);
        chk("async_rd_base", 32'(rd_base), 32'(FS));
        chk("async_disp_valid", 32'(disp_valid), 32'd0);
        chk("async_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("async_repeat_cnt", 32'(repeat_cnt), 32'd0);
        @(posedge clk); #1;
        expect_load(1, 1, 24'd0, FS, 0, 0, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        expect_load(1, 0, FS2, FS, 0, 0, 0);
        pulse(1, 0);
        repeat (3) @(posedge clk);

        #1 chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
